// File: rtl/reg_dump_uart.sv
// Debug readout: snapshots the CPU register file on request and streams it out as a framed
// 8N1 UART byte stream (sync 0xA5, index + 4 data bytes per register MSB first, XOR checksum).
module reg_dump_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_REGS     = 26
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NUM_REGS*32-1:0] reg_flat,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [7:0]  BYTE_LAST = 8'(5 * NUM_REGS + 1);
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                  state_r;
    logic [15:0]             baud_cnt_r;
    logic [2:0]              bit_cnt_r;
    logic [7:0]              byte_cnt_r;
    logic [7:0]              shift_r;
    logic [7:0]              csum_r;
    logic [NUM_REGS*32-1:0]  snap_r;
    logic                    tx_r;
    logic                    busy_r;
    logic                    done_r;
    logic [7:0]              sel_s;

    // Byte counter layout: 0 = sync, 1+5k = index k, 2+5k..5+5k = reg k MSB..LSB, last = checksum.
    function automatic logic [7:0] sel_byte(input logic [7:0] cnt,
                                            input logic [7:0] csum,
                                            input logic [NUM_REGS*32-1:0] snap);
        logic [7:0]  n;
        logic [7:0]  k;
        logic [2:0]  m;
        logic [31:0] word;
        logic [7:0]  res;
        n    = cnt - 8'd1;
        k    = n / 8'd5;
        m    = 3'(n % 8'd5);
        word = 32'h0000_0000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (k == 8'(i)) begin
                word = snap[i*32 +: 32];
            end
        end
        case (m)
            3'd0:    res = k;
            3'd1:    res = word[31:24];
            3'd2:    res = word[23:16];
            3'd3:    res = word[15:8];
            3'd4:    res = word[7:0];
            default: res = 8'h00;
        endcase
        if (cnt == 8'd0) begin
            res = SYNC_BYTE;
        end else if (cnt == BYTE_LAST) begin
            res = csum;
        end
        return res;
    endfunction

    // Next byte to load, chosen from the byte counter.
    always_comb begin
        sel_s = sel_byte(byte_cnt_r, csum_r, snap_r);
    end

    // Frame FSM with counters; tx/done follow the state one cycle later as registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            baud_cnt_r <= 16'd0;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= 8'd0;
            shift_r    <= 8'd0;
            csum_r     <= 8'd0;
            snap_r     <= '0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                S_START: tx_r <= 1'b0;
                S_DATA:  tx_r <= shift_r[0];
                default: tx_r <= 1'b1;
            endcase
            done_r <= (state_r == S_DONE);

            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        snap_r     <= reg_flat;
                        csum_r     <= 8'd0;
                        byte_cnt_r <= 8'd0;
                        baud_cnt_r <= 16'd0;
                        bit_cnt_r  <= 3'd0;
                        busy_r     <= 1'b1;
                        state_r    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    shift_r    <= sel_s;
                    baud_cnt_r <= 16'd0;
                    // The sync byte is excluded, and the checksum byte is what we're building.
                    if ((byte_cnt_r != 8'd0) && (byte_cnt_r != BYTE_LAST)) begin
                        csum_r <= csum_r ^ sel_s;
                    end
                    state_r <= S_START;
                end
                S_START: begin
                    if (baud_cnt_r == BAUD_LAST) begin
                        baud_cnt_r <= 16'd0;
                        bit_cnt_r  <= 3'd0;
                        state_r    <= S_DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt_r == BAUD_LAST) begin
                        baud_cnt_r <= 16'd0;
                        shift_r    <= {1'b0, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= S_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                S_STOP: begin
                    if (baud_cnt_r == BAUD_LAST) begin
                        baud_cnt_r <= 16'd0;
                        if (byte_cnt_r == BYTE_LAST) begin
                            state_r <= S_DONE;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 8'd1;
                            state_r    <= S_LOAD;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                S_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_reg_dump_uart.sv
// Bench for reg_dump_uart: decodes the UART stream and scoreboards it against a frame model,
// and checks frame timing, done/busy behaviour, snapshot coherence and reset.
module tb_reg_dump_uart;

    localparam int C         = 4;
    localparam int NR        = 26;
    localparam int BYTE_CYC  = 10 * C + 1;
    localparam int FRAME_CYC = 132 * BYTE_CYC + 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [NR*32-1:0] reg_flat = '0;
    logic             tx;
    logic             busy;
    logic             done;

    int tests = 0;
    int fails = 0;

    logic [8:0] rx_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        int          sel;
        logic [31:0] val;
        int          mode;      // 0 plain, 1 snapshot change after start, 2 extra starts while busy
        logic [7:0]  exp_csum;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    reg_dump_uart #(.CLKS_PER_BIT(C), .NUM_REGS(NR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .reg_flat (reg_flat),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    // UART receiver: each bit is sampled at the first falling clk edge inside it.
    initial begin : decoder
        logic [7:0] b;
        logic       stop_bit;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = tx;
                end
                repeat (C) @(negedge clk);
                stop_bit = tx;
                rx_q.push_back({stop_bit, b});
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame model built from the register values driven at the start edge.
    task automatic push_frame();
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < NR; k++) begin
            w = reg_flat[k*32 +: 32];
            exp_q.push_back(8'(k));
            cs = cs ^ 8'(k);
            for (int j = 3; j >= 0; j--) begin
                exp_q.push_back(w[j*8 +: 8]);
                cs = cs ^ w[j*8 +: 8];
            end
        end
        exp_q.push_back(cs);
    endtask

    task automatic run_frame(input int mode, output logic [7:0] last_byte);
        int         cyc;
        int         fall_cyc;
        int         done_cyc;
        int         done_cnt;
        int         busy_gap;
        logic       busy_at_done;
        logic [8:0] got;
        logic [7:0] want;
        int         idx;
        last_byte    = 8'h00;
        busy_at_done = 1'b1;
        @(negedge clk);
        start = 1'b1;
        push_frame();
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start_edge", 32'(busy), 32'd1);
        cyc      = 1;
        fall_cyc = 0;
        done_cyc = 0;
        done_cnt = 0;
        busy_gap = 0;
        while (cyc < FRAME_CYC + 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mode == 1 && cyc == 3) reg_flat[31:0] = 32'h5555_5555;
            if (mode == 2 && (cyc == 10 * BYTE_CYC + 20 || cyc == 100 * BYTE_CYC + 20)) start = 1'b1;
            else start = 1'b0;
            if (fall_cyc == 0 && tx == 1'b0) fall_cyc = cyc;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc     = cyc;
                    busy_at_done = busy;
                end
            end
            if (done_cyc == 0 && !busy) busy_gap++;
            if (done_cyc != 0 && cyc == done_cyc + 60) break;
        end
        start = 1'b0;
        check("tx_fall_cycle", 32'(fall_cyc), 32'd3);
        check("done_cycle", 32'(done_cyc), 32'(FRAME_CYC));
        check("done_pulse_count", 32'(done_cnt), 32'd1);
        check("busy_continuous", 32'(busy_gap), 32'd0);
        check("busy_low_at_done", 32'(busy_at_done), 32'd0);
        check("idle_after_frame", 32'(busy), 32'd0);
        check("rx_byte_count", 32'(rx_q.size()), 32'd132);
        idx = 0;
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            if (got[8] !== 1'b1) check($sformatf("stop_bit[%0d]", idx), 32'(got[8]), 32'd1);
            check($sformatf("byte[%0d]", idx), 32'(got[7:0]), 32'(want));
            last_byte = got[7:0];
            idx++;
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin : main
        logic [7:0] lb;
        int         tx_edges;
        int         busy_seen;
        logic       prev_tx;

        vecs[0] = '{sel: 0,  val: 32'h0000_0000, mode: 0, exp_csum: 8'h01};
        vecs[1] = '{sel: 5,  val: 32'h1234_5678, mode: 0, exp_csum: 8'h09};
        vecs[2] = '{sel: 0,  val: 32'hAAAA_AAAA, mode: 1, exp_csum: 8'h01};
        vecs[3] = '{sel: 25, val: 32'hDEAD_BEEF, mode: 2, exp_csum: 8'h23};

        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        for (int v = 0; v < 4; v++) begin
            reg_flat = '0;
            reg_flat[vecs[v].sel*32 +: 32] = vecs[v].val;
            run_frame(vecs[v].mode, lb);
            check($sformatf("checksum_vec%0d", v), 32'(lb), 32'(vecs[v].exp_csum));
            repeat (10) @(posedge clk);
        end

        // Reset during the data bits of byte 40 (reg7 LSB, all zero so tx is low).
        reg_flat = '0;
        reg_flat[25*32 +: 32] = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40 * BYTE_CYC + 1 + C + 3 * C) @(posedge clk);
        #1;
        check("pre_reset_tx_low", 32'(tx), 32'd0);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_tx", 32'(tx), 32'd1);
        check("midframe_reset_busy", 32'(busy), 32'd0);
        check("midframe_reset_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        tx_edges  = 0;
        busy_seen = 0;
        prev_tx   = tx;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== prev_tx) tx_edges++;
            if (busy) busy_seen++;
            prev_tx = tx;
        end
        check("idle_tx_transitions", 32'(tx_edges), 32'd0);
        check("idle_busy_cycles", 32'(busy_seen), 32'd0);
        rx_q.delete();

        run_frame(0, lb);
        check("post_reset_checksum", 32'(lb), 32'h0000_0023);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
